bus_trace_capture: RTL and testbench

// - Parametrised successor to the serial bus debugger: records completed 68030-style bus cycles into a circular trace RAM.
// - Freezes on a selectable trigger after a post-trigger count, then drains records oldest-first as a byte stream for the USART TX.
// - Sits between the bus pins (via level shifters) and the serial transmitter; runs entirely on comm_clock.

---
 rtl/fidget_trace_pkg.sv | 18 +
 rtl/bus_cycle_sampler.sv | 66 ++++++
 rtl/bus_trace_capture.sv | 140 ++++++++++++++
 tb/tb_bus_trace_capture.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fidget_trace_pkg.sv
// fidget_trace_pkg: shared state encodings, trigger modes, flag positions and record sizing
package fidget_trace_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DRAIN} state_t;
  localparam logic [1:0] TRIG_MANUAL  = 2'd0;
  localparam logic [1:0] TRIG_ADDR    = 2'd1;
  localparam logic [1:0] TRIG_ADDR_RW = 2'd2;
  localparam logic [1:0] TRIG_BERR    = 2'd3;
  localparam int FLAG_RW     = 7;
  localparam int FLAG_BERR   = 6;
  localparam int FLAG_DSACK1 = 5;
  localparam int FLAG_DSACK0 = 4;
  function automatic int record_bytes(input int aw, input int dw);
    return 1 + aw / 8 + dw / 8;
  endfunction
  function automatic int bus_width(input int aw, input int dw);
    return (aw > dw) ? aw : dw;
  endfunction
endpackage

// File: rtl/bus_cycle_sampler.sv
// bus_cycle_sampler: synchronises bus strobes and emits one {flags, addr, data} record per terminated cycle
module bus_cycle_sampler
  import fidget_trace_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int BUS_WIDTH = bus_width(ADDR_WIDTH, DATA_WIDTH),
  localparam int REC_WIDTH = 8 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                 comm_clock,
  input  logic                 comm_reset_n,
  input  logic                 bus_as_n,
  input  logic                 bus_ds_n,
  input  logic                 bus_rw,
  input  logic                 bus_dsack0_n,
  input  logic                 bus_dsack1_n,
  input  logic                 bus_berr_n,
  input  logic [BUS_WIDTH-1:0] bus_ad,
  output logic [REC_WIDTH-1:0] record,
  output logic                 record_valid
);
  logic [5:0] sync1, sync2;
  logic [BUS_WIDTH-1:0] ad1, ad2;
  logic as_d, active, rw_q;
  logic [3:0] flags_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic as_n_s, ds_n_s, rw_s, dsack0_n_s, dsack1_n_s, berr_n_s, term;
  assign {as_n_s, ds_n_s, rw_s, dsack0_n_s, dsack1_n_s, berr_n_s} = sync2;
  // DSACK only counts once DS qualifies the data phase; BERR terminates on its own
  assign term = !berr_n_s || (!ds_n_s && (!dsack0_n_s || !dsack1_n_s));
  assign record = {flags_q, 4'b0, addr_q, data_q};
  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      sync1        <= '1;
      sync2        <= '1;
      ad1          <= '0;
      ad2          <= '0;
      as_d         <= 1'b1;
      active       <= 1'b0;
      rw_q         <= 1'b0;
      flags_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      record_valid <= 1'b0;
    end else begin
      sync1        <= {bus_as_n, bus_ds_n, bus_rw, bus_dsack0_n, bus_dsack1_n, bus_berr_n};
      sync2        <= sync1;
      ad1          <= bus_ad;
      ad2          <= ad1;
      as_d         <= as_n_s;
      record_valid <= 1'b0;
      if (as_n_s) active <= 1'b0;
      else if (as_d) begin
        active <= 1'b1;
        addr_q <= ad2[ADDR_WIDTH-1:0];
        rw_q   <= rw_s;
      end else if (active && term) begin
        active       <= 1'b0;
        data_q       <= ad2[DATA_WIDTH-1:0];
        flags_q      <= {rw_q, !berr_n_s, !dsack1_n_s, !dsack0_n_s};
        record_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_trace_capture.sv
// bus_trace_capture: circular bus-cycle trace with selectable trigger, drained oldest-first as a byte stream
module bus_trace_capture
  import fidget_trace_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int POST_TRIGGER = 128,
  localparam int BUS_WIDTH   = bus_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                  comm_clock,
  input  logic                  comm_reset_n,
  input  logic                  arm,
  input  logic                  dump_start,
  input  logic [1:0]            trig_mode,
  input  logic [ADDR_WIDTH-1:0] trig_addr,
  input  logic [ADDR_WIDTH-1:0] trig_mask,
  input  logic                  trig_rw,
  input  logic                  bus_as_n,
  input  logic                  bus_ds_n,
  input  logic                  bus_rw,
  input  logic                  bus_dsack0_n,
  input  logic                  bus_dsack1_n,
  input  logic                  bus_berr_n,
  input  logic [BUS_WIDTH-1:0]  bus_ad,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  armed,
  output logic                  triggered,
  output logic                  draining
);
  localparam int RW  = 8 + ADDR_WIDTH + DATA_WIDTH;
  localparam int RB  = record_bytes(ADDR_WIDTH, DATA_WIDTH);
  localparam int PW  = $clog2(DEPTH);
  localparam int BCW = $clog2(RB + 1);
  localparam logic [PW:0] FULL   = (PW+1)'(DEPTH);
  localparam logic [PW:0] POST_N = (PW+1)'(POST_TRIGGER);
  localparam bit POST_ZERO  = POST_TRIGGER == 0;
  localparam bit POST_SHORT = POST_TRIGGER <= 1;
  state_t state, state_nx;
  logic [RW-1:0] record, ram_q, shreg;
  logic [RW-1:0] ram [DEPTH];
  logic rec_valid, rec_we, addr_hit, rec_hit, man_hit, accept, shreg_free, load, issue;
  logic arm_now, drain_go, pf_valid, ds_d;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx;
  logic [PW:0] count, count_nx, post_cnt, fetch_left;
  logic [BCW-1:0] bcnt;
  bus_cycle_sampler #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_sampler (
    .comm_clock   (comm_clock),
    .comm_reset_n (comm_reset_n),
    .bus_as_n     (bus_as_n),
    .bus_ds_n     (bus_ds_n),
    .bus_rw       (bus_rw),
    .bus_dsack0_n (bus_dsack0_n),
    .bus_dsack1_n (bus_dsack1_n),
    .bus_berr_n   (bus_berr_n),
    .bus_ad       (bus_ad),
    .record       (record),
    .record_valid (rec_valid)
  );
  always_comb begin
    rec_we     = rec_valid && (state == ST_ARMED || state == ST_POST);
    addr_hit   = ((record[DATA_WIDTH +: ADDR_WIDTH] ^ trig_addr) & trig_mask) == '0;
    rec_hit    = rec_we && state == ST_ARMED &&
                 (trig_mode == TRIG_ADDR    ? addr_hit :
                  trig_mode == TRIG_ADDR_RW ? addr_hit && record[RW-8+FLAG_RW] == trig_rw :
                  trig_mode == TRIG_BERR    && record[RW-8+FLAG_BERR]);
    man_hit    = trig_mode == TRIG_MANUAL && dump_start && !ds_d;
    wr_ptr_nx  = rec_we ? wr_ptr + PW'(1) : wr_ptr;
    count_nx   = (rec_we && count != FULL) ? count + (PW+1)'(1) : count;
    accept     = out_valid && out_ready;
    shreg_free = bcnt == '0 || (bcnt == BCW'(1) && accept);
    load       = state == ST_DRAIN && shreg_free && pf_valid;
    // keep one record prefetched so back-to-back records stream without a gap
    issue      = state == ST_DRAIN && fetch_left != '0 && (!pf_valid || load);
    arm_now    = state == ST_IDLE && arm;
    drain_go   = state != ST_DRAIN && state_nx == ST_DRAIN;
  end
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (arm) state_nx = ST_ARMED;
      ST_ARMED: if (rec_hit) state_nx = POST_SHORT ? ST_DRAIN : ST_POST;
                else if (man_hit) state_nx = POST_ZERO ? ST_DRAIN : ST_POST;
      ST_POST:  if (rec_we && post_cnt + (PW+1)'(1) == POST_N) state_nx = ST_DRAIN;
      ST_DRAIN: if (fetch_left == '0 && !pf_valid && shreg_free) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge comm_clock) begin
    if (rec_we) ram[wr_ptr] <= record;
    if (issue) ram_q <= ram[rd_ptr];
  end
  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      post_cnt   <= '0;
      fetch_left <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      pf_valid   <= 1'b0;
      ds_d       <= 1'b0;
    end else begin
      ds_d     <= dump_start;
      wr_ptr   <= arm_now ? '0 : wr_ptr_nx;
      count    <= arm_now ? '0 : count_nx;
      post_cnt <= arm_now ? '0 :
                  rec_hit ? (PW+1)'(1) :
                  (rec_we && state == ST_POST) ? post_cnt + (PW+1)'(1) : post_cnt;
      // oldest entry sits count records behind the write pointer, modulo DEPTH
      if (drain_go) begin
        rd_ptr     <= wr_ptr_nx - count_nx[PW-1:0];
        fetch_left <= count_nx;
      end else if (issue) begin
        rd_ptr     <= rd_ptr + PW'(1);
        fetch_left <= fetch_left - (PW+1)'(1);
      end
      pf_valid <= issue || (pf_valid && !load);
      if (load) begin
        shreg <= ram_q;
        bcnt  <= BCW'(RB);
      end else if (accept) begin
        shreg <= shreg << 8;
        bcnt  <= bcnt - BCW'(1);
      end
    end
  end
  assign out_data  = shreg[RW-1 -: 8];
  assign out_valid = bcnt != '0;
  assign armed     = state == ST_ARMED || state == ST_POST;
  assign triggered = state == ST_POST || state == ST_DRAIN;
  assign draining  = state == ST_DRAIN;
endmodule

// File: tb/tb_bus_trace_capture.sv
// tb_bus_trace_capture: directed capture/trigger/drain scenarios checked against a byte-level model
module tb_bus_trace_capture;
  logic clk = 1'b0, rst_n = 1'b0;
  logic arm = 1'b0, dump_start = 1'b0, trig_rw = 1'b0, out_ready = 1'b0;
  logic [1:0] trig_mode = 2'd0;
  logic [31:0] trig_addr = '0, trig_mask = '0, bus_ad = '0;
  logic bus_as_n = 1'b1, bus_ds_n = 1'b1, bus_rw = 1'b1;
  logic bus_dsack0_n = 1'b1, bus_dsack1_n = 1'b1, bus_berr_n = 1'b1;
  logic [7:0] out_data;
  logic out_valid, armed, triggered, draining;
  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  bus_trace_capture #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(8), .POST_TRIGGER(2)) dut (
    .comm_clock(clk), .comm_reset_n(rst_n), .arm(arm), .dump_start(dump_start),
    .trig_mode(trig_mode), .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_rw(trig_rw),
    .bus_as_n(bus_as_n), .bus_ds_n(bus_ds_n), .bus_rw(bus_rw), .bus_dsack0_n(bus_dsack0_n),
    .bus_dsack1_n(bus_dsack1_n), .bus_berr_n(bus_berr_n), .bus_ad(bus_ad),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .armed(armed), .triggered(triggered), .draining(draining)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // kind: 0 both DSACKs, 1 BERR, 2 no termination, 3 DSACK0 only
  task automatic rec(input logic [31:0] a, input logic [31:0] d, input logic rw, input int kind, input bit keep);
    logic [7:0] f;
    f = {rw, kind == 1, kind == 0, kind == 0 || kind == 3, 4'b0};
    @(negedge clk);
    bus_ad = a; bus_rw = rw; bus_as_n = 1'b0; bus_ds_n = 1'b0;
    repeat (4) @(negedge clk);
    bus_ad = d;
    bus_dsack0_n = !(kind == 0 || kind == 3);
    bus_dsack1_n = !(kind == 0);
    bus_berr_n   = !(kind == 1);
    repeat (5) @(negedge clk);
    bus_as_n = 1'b1; bus_ds_n = 1'b1; bus_dsack0_n = 1'b1; bus_dsack1_n = 1'b1; bus_berr_n = 1'b1;
    repeat (4) @(negedge clk);
    if (keep) begin
      exp_q.push_back(f);
      for (int i = 3; i >= 0; i--) exp_q.push_back(a[8*i +: 8]);
      for (int i = 3; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
    end
  endtask
  task automatic pulse_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask
  task automatic pulse_dump();
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
  endtask
  task automatic drain(input int n, input bit rnd);
    int got = 0, cyc = 0, first = -1, last = 0;
    logic hold_v = 1'b0;
    logic [7:0] hold_d = '0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      if (hold_v) chk("hold", {out_valid, out_data}, {1'b1, hold_d});
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk($sformatf("byte%0d", got), out_data, exp_q[got]);
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        hold_v = 1'b0;
      end else begin
        hold_v = out_valid;
        hold_d = out_data;
      end
      cyc++;
    end
    chk("drain_count", got, n);
    if (!rnd) chk("no_bubble", last - first, n - 1);
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_drain", {armed, triggered, draining, out_valid}, 4'b0000);
    exp_q.delete();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_status", {armed, triggered, draining}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_status", {armed, triggered, draining}, 3'b000);
    // manual trigger, three reads then two post-trigger reads
    pulse_arm();
    chk("t1_armed", {armed, triggered, draining}, 3'b100);
    rec(32'h1000, 32'hAA55AA55, 1'b1, 0, 1'b1);
    rec(32'h1004, 32'hAA55AA55, 1'b1, 0, 1'b1);
    rec(32'h1008, 32'hAA55AA55, 1'b1, 0, 1'b1);
    pulse_dump();
    chk("t1_post", {armed, triggered, draining}, 3'b110);
    rec(32'h100C, 32'hAA55AA55, 1'b1, 0, 1'b1);
    chk("t1_post2", {armed, triggered, draining}, 3'b110);
    rec(32'h1010, 32'hAA55AA55, 1'b1, 0, 1'b1);
    chk("t1_drain", {armed, triggered, draining}, 3'b011);
    drain(45, 1'b0);
    // address-match trigger with wrap: oldest retained record is n=6
    trig_mode = 2'd1; trig_addr = 32'h0C; trig_mask = 32'hFF;
    pulse_arm();
    for (int n = 0; n < 20; n++) rec(32'(n), 32'h100 + 32'(n), 1'b0, 3, n >= 6 && n <= 13);
    chk("t2_drain", {armed, triggered, draining}, 3'b011);
    drain(72, 1'b1);
    // bus-error trigger on the fifth write
    trig_mode = 2'd3;
    pulse_arm();
    for (int n = 1; n <= 4; n++) rec(32'h10 * 32'(n), 32'hD0 + 32'(n), 1'b0, 0, 1'b1);
    chk("t3_armed", {armed, triggered, draining}, 3'b100);
    rec(32'h50, 32'hDEADBEEF, 1'b0, 1, 1'b1);
    chk("t3_trig", {armed, triggered, draining}, 3'b110);
    rec(32'h60, 32'h12345678, 1'b0, 0, 1'b1);
    chk("t3_drain", {armed, triggered, draining}, 3'b011);
    drain(54, 1'b0);
    // unterminated AS writes nothing; arm during POST is ignored
    trig_mode = 2'd0;
    pulse_arm();
    rec(32'h2000, 32'h1, 1'b1, 2, 1'b0);
    chk("t4_noterm", {armed, triggered, draining}, 3'b100);
    rec(32'h2004, 32'h11223344, 1'b1, 0, 1'b1);
    pulse_dump();
    chk("t4_post", {armed, triggered, draining}, 3'b110);
    pulse_arm();
    chk("t4_arm_ign", {armed, triggered, draining}, 3'b110);
    rec(32'h2008, 32'h55667788, 1'b0, 3, 1'b1);
    rec(32'h200C, 32'h99AABBCC, 1'b1, 0, 1'b1);
    chk("t4_drain", {armed, triggered, draining}, 3'b011);
    drain(27, 1'b0);
    // reset in the middle of a drain, then a clean restart
    pulse_arm();
    rec(32'h3000, 32'hCAFE0001, 1'b1, 0, 1'b1);
    pulse_dump();
    rec(32'h3004, 32'hCAFE0002, 1'b1, 0, 1'b1);
    rec(32'h3008, 32'hCAFE0003, 1'b1, 0, 1'b1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_mid", {draining, out_valid}, 2'b11);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_data", out_data, 8'h00);
    chk("t5_rst_status", {armed, triggered, draining}, 3'b000);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pulse_arm();
    chk("t5_rearm", {armed, triggered, draining}, 3'b100);
    rec(32'h4000, 32'h0BADF00D, 1'b0, 0, 1'b1);
    pulse_dump();
    rec(32'h4004, 32'h0000FFFF, 1'b1, 3, 1'b1);
    rec(32'h4008, 32'hFFFF0000, 1'b0, 1, 1'b1);
    chk("t5_drain", {armed, triggered, draining}, 3'b011);
    drain(27, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
